// File: rtl/mem_access_ctrl_if.sv
// Request/response and byte-array bus bundle for mem_access_ctrl.
// slave = controller side, master = requester plus array side.
interface mem_access_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic [2:0] mem_adr;
  logic       mem_valid;
  logic       mem_rw;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, init_done,
    output mem_adr, mem_valid, mem_rw, mem_din
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, init_done,
    input  mem_adr, mem_valid, mem_rw, mem_din
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Clocked front-end for the 8-byte asynchronous array: sequences
// setup/strobe/hold phases, clears the array after reset.
module mem_access_ctrl #(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         INIT_CLEAR = 1,
  parameter logic [7:0] INIT_VALUE = 8'h00
) (
  input logic             i_clk,
  input logic             i_rst_n,
  mem_access_ctrl_if.slave bus
);

  localparam logic [2:0] S_ISETUP  = 3'd0;
  localparam logic [2:0] S_ISTROBE = 3'd1;
  localparam logic [2:0] S_IHOLD   = 3'd2;
  localparam logic [2:0] S_IDLE    = 3'd3;
  localparam logic [2:0] S_SETUP   = 3'd4;
  localparam logic [2:0] S_STROBE  = 3'd5;
  localparam logic [2:0] S_HOLD    = 3'd6;

  localparam logic [2:0] S_RST =
    (INIT_CLEAR != 0) ? S_ISETUP : S_IDLE;
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic       NO_INIT     = (INIT_CLEAR == 0);

  logic [2:0] r_state;
  logic [2:0] w_nstate;
  logic [7:0] r_cnt;
  logic       r_ready;
  logic       r_rsp_valid;
  logic [7:0] r_rdata;
  logic       r_init_done;
  logic [2:0] r_mem_adr;
  logic       r_mem_valid;
  logic       r_mem_rw;
  logic [7:0] r_mem_din;

  logic w_accept;
  logic w_setup_end;
  logic w_strobe_end;
  logic w_init_next;
  logic w_hold_cnt;

  assign w_accept     = bus.req_valid && r_ready;
  assign w_setup_end  = (r_cnt == SETUP_LAST);
  assign w_strobe_end = (r_cnt == STROBE_LAST);
  assign w_init_next  = r_init_done || NO_INIT ||
                        (r_state == S_IHOLD && w_nstate == S_IDLE);
  // The first init cycle only loads rw/din, so setup counts from the next.
  assign w_hold_cnt   = (r_state == S_ISETUP) && !r_mem_rw;

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      S_ISETUP:  if (r_mem_rw && w_setup_end) w_nstate = S_ISTROBE;
      S_ISTROBE: if (w_strobe_end) w_nstate = S_IHOLD;
      S_IHOLD:   w_nstate = (r_mem_adr == 3'd7) ? S_IDLE : S_ISETUP;
      S_IDLE:    if (w_accept) w_nstate = S_SETUP;
      S_SETUP:   if (w_setup_end) w_nstate = S_STROBE;
      S_STROBE:  if (w_strobe_end) w_nstate = S_HOLD;
      S_HOLD:    w_nstate = S_IDLE;
      default:   w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_init_done <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_din   <= '0;
    end else begin
      r_state     <= w_nstate;
      r_cnt       <= (w_nstate != r_state || w_hold_cnt) ?
                     8'd0 : r_cnt + 8'd1;
      r_init_done <= w_init_next;
      r_ready     <= (w_nstate == S_IDLE) && w_init_next;
      r_mem_valid <= (w_nstate == S_STROBE) ||
                     (w_nstate == S_ISTROBE);
      r_rsp_valid <= (w_nstate == S_HOLD) && !r_mem_rw;
      if (r_state == S_STROBE && w_strobe_end && !r_mem_rw)
        r_rdata <= bus.mem_dout;
      if (w_hold_cnt) begin
        r_mem_rw  <= 1'b1;
        r_mem_din <= INIT_VALUE;
      end
      if (r_state == S_IHOLD && w_nstate == S_ISETUP)
        r_mem_adr <= r_mem_adr + 3'd1;
      if (r_state == S_IDLE && w_accept) begin
        r_mem_adr <= bus.req_addr;
        r_mem_din <= bus.req_wdata;
        r_mem_rw  <= bus.req_write;
      end
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.init_done = r_init_done;
  assign bus.mem_adr   = r_mem_adr;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_rw    = r_mem_rw;
  assign bus.mem_din   = r_mem_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: default-timing instance plus a
// slow-timing instance, each with a behavioural byte-array model.
module tb_mem_access_ctrl;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if b0 ();
  mem_access_ctrl_if b1 ();

  mem_access_ctrl u0 (.i_clk(clk), .i_rst_n(rst0), .bus(b0));

  mem_access_ctrl #(
    .SETUP_CYC(2), .STROBE_CYC(4), .INIT_CLEAR(1), .INIT_VALUE(8'h00)
  ) u1 (.i_clk(clk), .i_rst_n(rst1), .bus(b1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Asynchronous byte arrays, written while strobed with rw=1.
  logic [7:0] arr0 [8];
  logic [7:0] arr1 [8];
  bit pre_done = 1'b0;
  always @(negedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 8; i++) begin
        arr0[i] <= 8'hE0 | 8'(i);
        arr1[i] <= 8'hD0 | 8'(i);
      end
      pre_done <= 1'b1;
    end else begin
      if (b0.mem_valid && b0.mem_rw) arr0[b0.mem_adr] <= b0.mem_din;
      if (b1.mem_valid && b1.mem_rw) arr1[b1.mem_adr] <= b1.mem_din;
    end
  end
  assign b0.mem_dout = arr0[b0.mem_adr];
  assign b1.mem_dout = arr1[b1.mem_adr];

  // Expected byte contents as seen by the requester.
  logic [7:0] model [8];

  // Strobe monitor and address/data stability checker for instance 0.
  bit mon0 = 1'b0;
  logic [11:0] strobes [$];
  logic        pv = 1'b0;
  logic [11:0] pbus = '0;
  logic        prst = 1'b0;
  always @(negedge clk) begin
    if (mon0 && b0.mem_valid)
      strobes.push_back({b0.mem_adr, b0.mem_rw, b0.mem_din});
    if (rst0 && prst &&
        {b0.mem_adr, b0.mem_rw, b0.mem_din} != pbus)
      chk("bus_change_near_strobe", int'({pv, b0.mem_valid}), 0);
    pv   <= b0.mem_valid;
    pbus <= {b0.mem_adr, b0.mem_rw, b0.mem_din};
    prst <= rst0;
  end

  task automatic acc0(input bit wr, input logic [2:0] a,
                      input logic [7:0] d, output int rdy_lat,
                      output int rsp_lat, output logic [7:0] rd,
                      output bit ok);
    int n;
    rdy_lat = -1; rsp_lat = -1; rd = '0; ok = 1'b0;
    @(negedge clk);
    b0.req_write = wr; b0.req_addr = a;
    b0.req_wdata = d;  b0.req_valid = 1'b1;
    n = 0;
    while (!b0.req_ready && n < 60) begin
      @(negedge clk); n++;
    end
    if (!b0.req_ready) begin
      b0.req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    b0.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (b0.rsp_valid && rsp_lat < 0) begin
        rsp_lat = c; rd = b0.rsp_rdata;
      end
      if (b0.req_ready) begin
        rdy_lat = c; break;
      end
      @(negedge clk);
    end
    ok = 1'b1;
    if (wr) model[a] = d;
  endtask

  task automatic acc1(input bit wr, input logic [2:0] a,
                      input logic [7:0] d, output int rsp_lat,
                      output int strb, output logic [7:0] rd,
                      output int rdy_lat);
    int n;
    rsp_lat = -1; strb = 0; rd = '0; rdy_lat = -1;
    @(negedge clk);
    b1.req_write = wr; b1.req_addr = a;
    b1.req_wdata = d;  b1.req_valid = 1'b1;
    n = 0;
    while (!b1.req_ready && n < 60) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    b1.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (b1.mem_valid) strb++;
      if (b1.rsp_valid && rsp_lat < 0) begin
        rsp_lat = c; rd = b1.rsp_rdata;
      end
      if (b1.req_ready) begin
        rdy_lat = c; break;
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [$];

  task automatic run_vec(input vec_t v, input string tag);
    int rl, sl;
    logic [7:0] rd;
    bit ok;
    acc0(v.wr, v.a, v.d, rl, sl, rd, ok);
    chk({tag, "_accept"}, int'(ok), 1);
    chk({tag, "_ready_lat"}, rl, 5);
    chk({tag, "_rsp_lat"}, sl, v.wr ? -1 : 4);
    if (!v.wr) chk({tag, "_rdata"}, int'(rd), int'(v.exp));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, cyc, last, nacc, rl, sl, st;
    logic [7:0] rd, e;
    bit ok, wr;
    logic [2:0] a;
    vec_t v;

    b0.req_valid = 0; b0.req_write = 0;
    b0.req_addr = 0;  b0.req_wdata = 0;
    b1.req_valid = 0; b1.req_write = 0;
    b1.req_addr = 0;  b1.req_wdata = 0;
    repeat (3) @(negedge clk);

    // Reset state, then the init walk.
    chk("rst_outputs", int'({b0.req_ready, b0.rsp_valid,
        b0.rsp_rdata, b0.init_done, b0.mem_adr, b0.mem_valid,
        b0.mem_rw, b0.mem_din}), 0);
    mon0 = 1'b1;
    rst0 = 1'b1;
    n = 0;
    while (!b0.mem_rw && n < 10) begin
      @(negedge clk); n++;
    end
    cyc = 0;
    while (!b0.init_done && cyc < 100) begin
      chk("ready_during_init", int'(b0.req_ready), 0);
      @(negedge clk); cyc++;
    end
    mon0 = 1'b0;
    chk("init_cycles", cyc, 32);
    chk("ready_after_init", int'(b0.req_ready), 1);
    chk("init_strobe_count", strobes.size(), 16);
    for (int i = 0; i < 16 && i < strobes.size(); i++)
      chk("init_strobe", int'(strobes[i]),
          int'({3'(i / 2), 1'b1, 8'h00}));
    for (int i = 0; i < 8; i++) begin
      chk("array_cleared", int'(arr0[i]), 0);
      model[i] = 8'h00;
    end

    // Directed table: A5 to addr 3, then 8 distinct bytes read back 7..0.
    v.wr = 1; v.a = 3; v.d = 8'hA5; v.exp = 0; vt.push_back(v);
    v.wr = 0; v.a = 3; v.d = 8'h00; v.exp = 8'hA5; vt.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v.wr = 1; v.a = 3'(i); v.d = 8'h10 + 8'(i); v.exp = 0;
      vt.push_back(v);
    end
    for (int i = 7; i >= 0; i--) begin
      v.wr = 0; v.a = 3'(i); v.d = 0; v.exp = 8'h10 + 8'(i);
      vt.push_back(v);
    end
    foreach (vt[i]) run_vec(vt[i], "table");

    // Random traffic against the byte model.
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 3'($urandom_range(0, 7));
      e  = model[a];
      acc0(wr, a, 8'($urandom), rl, sl, rd, ok);
      chk("rand_accept", int'(ok), 1);
      chk("rand_ready_lat", rl, 5);
      if (!wr) chk("rand_rdata", int'(rd), int'(e));
    end

    // Continuously valid request: accepts every 5 cycles.
    @(negedge clk);
    b0.req_write = 0; b0.req_addr = 3'd2; b0.req_valid = 1'b1;
    last = -1; nacc = 0;
    for (int c = 0; c < 22; c++) begin
      if (b0.req_ready) begin
        if (last >= 0) chk("accept_spacing", c - last, 5);
        last = c; nacc++;
      end
      @(negedge clk);
    end
    b0.req_valid = 1'b0;
    chk("accept_count", nacc, 5);
    n = 0;
    while (!b0.req_ready && n < 10) begin
      @(negedge clk); n++;
    end
    chk("ready_after_burst", int'(b0.req_ready), 1);

    // Reset in the middle of a write strobe.
    @(negedge clk);
    b0.req_write = 1; b0.req_addr = 3'd5;
    b0.req_wdata = 8'h3C; b0.req_valid = 1'b1;
    @(negedge clk);
    b0.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_strobe", int'(b0.mem_valid), 1);
    #2 rst0 = 1'b0;
    #1 chk("abort_valid_drop", int'(b0.mem_valid), 0);
    chk("abort_init_clear", int'(b0.init_done), 0);
    repeat (2) @(negedge clk);
    rst0 = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    n = 0;
    while (!b0.init_done && n < 100) begin
      @(negedge clk); n++;
    end
    chk("reinit_done", int'(b0.init_done), 1);
    v.wr = 0; v.a = 5; v.d = 0; v.exp = 8'h00;
    run_vec(v, "abort_read");
    v.wr = 0; v.a = 2; v.d = 0; v.exp = 8'h00;
    run_vec(v, "abort_read2");

    // Slow-timing instance: SETUP 2, STROBE 4.
    chk("slow_rst_outputs", int'({b1.req_ready, b1.rsp_valid,
        b1.init_done, b1.mem_valid, b1.mem_rw}), 0);
    rst1 = 1'b1;
    n = 0;
    while (!b1.mem_rw && n < 10) begin
      @(negedge clk); n++;
    end
    cyc = 0;
    while (!b1.init_done && cyc < 200) begin
      @(negedge clk); cyc++;
    end
    chk("slow_init_cycles", cyc, 56);
    acc1(1'b1, 3'd6, 8'h5A, sl, st, rd, rl);
    chk("slow_write_strobes", st, 4);
    chk("slow_write_ready_lat", rl, 8);
    chk("slow_write_rsp", sl, -1);
    acc1(1'b0, 3'd6, 8'h00, sl, st, rd, rl);
    chk("slow_read_lat", sl, 7);
    chk("slow_read_strobes", st, 4);
    chk("slow_read_data", int'(rd), 8'h5A);
    acc1(1'b0, 3'd1, 8'h00, sl, st, rd, rl);
    chk("slow_read_cleared", int'(rd), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
